// File: rtl/timer_pkg.sv
// Shared encodings for the timer block: clock-source select values and default
// prescaler divider width.
package timer_pkg;

   localparam int DIV_W_DEF = 4;

   localparam logic [2:0] CKS_STOP     = 3'd0;
   localparam logic [2:0] CKS_DIV2     = 3'd1;
   localparam logic [2:0] CKS_DIV4     = 3'd2;
   localparam logic [2:0] CKS_DIV8     = 3'd3;
   localparam logic [2:0] CKS_DIV16    = 3'd4;
   localparam logic [2:0] CKS_EXT_RISE = 3'd5;
   localparam logic [2:0] CKS_EXT_FALL = 3'd6;
   localparam logic [2:0] CKS_RSVD     = 3'd7;

endpackage

// File: rtl/timer_prescaler_edge_sync.sv
// Multi-flop synchroniser for an asynchronous pin, plus one history flop so
// that single-cycle rise/fall strobes can be taken from the settled samples.
module edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic async_i,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES:0] sync_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-1:0], async_i};
      end
   end

   // Bit SYNC_STAGES-1 is the first metastability-safe sample; the top bit is its history.
   assign rise_o =  sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES];
   assign fall_o = ~sync_q[SYNC_STAGES-1] &  sync_q[SYNC_STAGES];

endmodule

// File: rtl/timer_prescaler.sv
// Clock-enable generator for the 8-bit timer counter: registered one-cycle
// pulses every 2/4/8/16 cycles or on a synchronised external edge.
module timer_prescaler
   import timer_pkg::*;
#(
   parameter int DIV_W       = DIV_W_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [2:0]       cks,
   input  logic             ext_clk,
   output logic             clk_ena,
   output logic [DIV_W-1:0] div_cnt
);

   logic [2:0]       cks_q;
   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] div_d1_q, div_d1_d;
   logic             clk_ena_q, clk_ena_d;
   logic             ext_rise, ext_fall;
   logic             src_chg;
   logic [1:0]       bit_sel;

   edge_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_ext_sync (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .async_i (ext_clk),
      .rise_o  (ext_rise),
      .fall_o  (ext_fall)
   );

   assign src_chg = (cks != cks_q);
   assign bit_sel = cks[1:0] - 2'd1;

   // A source change behaves like a fresh enable: the divider restarts from zero.
   always_comb begin
      div_d     = '0;
      div_d1_d  = '0;
      clk_ena_d = 1'b0;
      if (en && !src_chg) begin
         case (cks)
            CKS_DIV2, CKS_DIV4, CKS_DIV8, CKS_DIV16: begin
               div_d     = div_q + 1'b1;
               div_d1_d  = div_q;
               clk_ena_d = div_q[bit_sel] & ~div_d1_q[bit_sel];
            end
            CKS_EXT_RISE: clk_ena_d = ext_rise;
            CKS_EXT_FALL: clk_ena_d = ext_fall;
            default:      clk_ena_d = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cks_q     <= CKS_STOP;
         div_q     <= '0;
         div_d1_q  <= '0;
         clk_ena_q <= 1'b0;
      end else begin
         cks_q     <= cks;
         div_q     <= div_d;
         div_d1_q  <= div_d1_d;
         clk_ena_q <= clk_ena_d;
      end
   end

   assign clk_ena = clk_ena_q;
   assign div_cnt = div_q;

endmodule
